// File: rtl/crc_byte_feeder_pkg.sv
// Shared definitions for the CRC byte feeder: register map, CTRL bit positions
// and the frame FSM state encoding.
package crc_feeder_pkg;

  localparam logic [3:0] ADDR_CTRL      = 4'h0;
  localparam logic [3:0] ADDR_DATA      = 4'h1;
  localparam logic [3:0] ADDR_LEN_LO    = 4'h2;
  localparam logic [3:0] ADDR_LEN_HI    = 4'h3;
  localparam logic [3:0] ADDR_STATUS    = 4'h4;
  localparam logic [3:0] ADDR_LEVEL     = 4'h5;
  localparam logic [3:0] ADDR_REMAIN_LO = 4'h6;
  localparam logic [3:0] ADDR_REMAIN_HI = 4'h7;

  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_CLR_FLAGS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/crc_byte_feeder_if.sv
// Register bus from the core plus the byte stream toward the CRC engine.
// The feeder is the slave; the core/engine side is the master.
interface crc_byte_feeder_if;

  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       crc_clear;
  logic       crc_byte_valid;
  logic [7:0] crc_byte;
  logic       crc_byte_ready;
  logic       done_irq;

  modport master (
    output address, data_write, data_in, crc_byte_ready,
    input  data_out, crc_clear, crc_byte_valid, crc_byte, done_irq
  );

  modport slave (
    input  address, data_write, data_in, crc_byte_ready,
    output data_out, crc_clear, crc_byte_valid, crc_byte, done_irq
  );

endinterface

// File: rtl/crc_feed_fifo.sv
// Small byte FIFO between core register writes and the CRC engine.
// Callers only assert push when there is room (or a pop in the same cycle) and pop when non-empty.
module crc_feed_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               push_data,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign full  = (level == LVL_MAX);
  assign empty = (level == '0);
  assign head  = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !push) begin
        level <= level - LVL_ONE;
      end
    end
  end

endmodule

// File: rtl/crc_byte_feeder.sv
// Frame sequencer: buffers core-written bytes, clears the CRC engine, then streams
// exactly LEN bytes over valid/ready and raises a sticky DONE flag.
module crc_byte_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  crc_byte_feeder_if.slave  bus
);

  import crc_feeder_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  feeder_state_t    state;
  feeder_state_t    state_next;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] remain;
  logic             done_flag;
  logic             ovf_flag;

  logic             wr_ctrl;
  logic             start_req;
  logic             abort_req;
  logic             clr_req;
  logic             push_req;
  logic             start_go;
  logic             push_ok;
  logic             push_drop;
  logic             xfer;
  logic             enter_done;
  logic             busy;

  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;
  logic [LVL_W-1:0] fifo_level;

  assign wr_ctrl   = bus.data_write && (bus.address == ADDR_CTRL);
  assign start_req = wr_ctrl && bus.data_in[CTRL_START];
  assign abort_req = wr_ctrl && bus.data_in[CTRL_ABORT];
  assign clr_req   = wr_ctrl && bus.data_in[CTRL_CLR_FLAGS];
  assign push_req  = bus.data_write && (bus.address == ADDR_DATA);

  assign start_go  = start_req && !abort_req && (state == IDLE);
  assign busy      = (state == CLEAR) || (state == STREAM);

  assign bus.crc_byte_valid = (state == STREAM) && !fifo_empty && (remain != '0);
  assign bus.crc_byte       = fifo_head;
  assign bus.crc_clear      = (state == CLEAR);
  assign bus.done_irq       = done_flag;

  assign xfer      = bus.crc_byte_valid && bus.crc_byte_ready;
  // A full FIFO still takes a byte when the engine drains one on the same edge.
  assign push_ok   = push_req && !abort_req && (!fifo_full || xfer);
  assign push_drop = push_req && !abort_req && fifo_full && !xfer;

  crc_feed_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .pop       (xfer),
    .flush     (abort_req),
    .push_data (bus.data_in),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_req) state_next = CLEAR;
      CLEAR:   state_next = (remain != '0) ? STREAM : DONE;
      STREAM:  if (xfer && (remain == LEN_ONE)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_req) begin
      state_next = IDLE;
    end
  end

  assign enter_done = (state_next == DONE) && (state != DONE);

  // REMAIN is only loaded at START so LEN may be reprogrammed during a running frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      remain    <= '0;
      done_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      state <= state_next;
      if (bus.data_write && (bus.address == ADDR_LEN_LO)) begin
        len[7:0] <= bus.data_in;
      end
      if (bus.data_write && (bus.address == ADDR_LEN_HI)) begin
        len[LEN_W-1:8] <= bus.data_in[LEN_W-9:0];
      end
      if (abort_req) begin
        remain <= '0;
      end else if (start_go) begin
        remain <= len;
      end else if (xfer) begin
        remain <= remain - LEN_ONE;
      end
      if (enter_done) begin
        done_flag <= 1'b1;
      end else if (clr_req || start_go) begin
        done_flag <= 1'b0;
      end
      if (push_drop) begin
        ovf_flag <= 1'b1;
      end else if (clr_req) begin
        ovf_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.data_out = 8'h00;
    case (bus.address)
      ADDR_STATUS:    bus.data_out = {3'b000, ovf_flag, done_flag, busy, fifo_full, fifo_empty};
      ADDR_LEVEL:     bus.data_out = 8'(fifo_level);
      ADDR_REMAIN_LO: bus.data_out = remain[7:0];
      ADDR_REMAIN_HI: bus.data_out = 8'(remain[LEN_W-1:8]);
      default:        bus.data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_crc_byte_feeder.sv
// Randomized and directed bench for crc_byte_feeder against a queue-based frame model.
module tb_crc_byte_feeder;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  crc_byte_feeder_if bus_if ();

  crc_byte_feeder #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int         vec_count  = 0;
  int         miss_count = 0;
  logic [7:0] last_read;
  logic [7:0] sent [$];

  logic [7:0]  q [$];
  logic [15:0] m_len;
  logic [15:0] m_remain;
  int          m_ph;
  bit          m_done;
  bit          m_ovf;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_len    = '0;
    m_remain = '0;
    m_ph     = 0;
    m_done   = 1'b0;
    m_ovf    = 1'b0;
  endfunction

  function automatic logic model_valid();
    return (m_ph == 2) && (q.size() != 0) && (m_remain != 0);
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] a);
    case (a)
      4'h4:    return {3'b000, m_ovf, m_done, (m_ph == 1 || m_ph == 2), (q.size() == DEPTH), (q.size() == 0)};
      4'h5:    return 8'(q.size());
      4'h6:    return m_remain[7:0];
      4'h7:    return m_remain[15:8];
      default: return 8'h00;
    endcase
  endfunction

  // Phases: 0 idle, 1 clearing the engine, 2 streaming, 3 frame just finished.
  function automatic void model_step(input logic [3:0] a, input logic wr, input logic [7:0] d, input logic rdy);
    bit start, abort, clr, push, xfer, room, finish;
    int old_ph;
    start  = wr && (a == 4'h0) && d[0];
    abort  = wr && (a == 4'h0) && d[1];
    clr    = wr && (a == 4'h0) && d[2];
    push   = wr && (a == 4'h1);
    xfer   = model_valid() && rdy;
    old_ph = m_ph;
    if (abort) begin
      q.delete();
      m_remain = '0;
      m_ph     = 0;
      if (clr) begin
        m_done = 1'b0;
        m_ovf  = 1'b0;
      end
    end else begin
      room   = (q.size() < DEPTH) || xfer;
      finish = (old_ph == 1 && m_remain == 0) || (old_ph == 2 && xfer && m_remain == 1);
      if (clr) m_ovf = 1'b0;
      if (xfer) begin
        q.delete(0);
        m_remain = m_remain - 16'd1;
      end
      if (push) begin
        if (room) q.push_back(d);
        else m_ovf = 1'b1;
      end
      case (old_ph)
        0: if (start) begin m_ph = 1; m_remain = m_len; end
        1: m_ph = (m_remain == 0) ? 3 : 2;
        2: if (finish) m_ph = 3;
        default: m_ph = 0;
      endcase
      if (finish) m_done = 1'b1;
      else if (clr || (start && old_ph == 0)) m_done = 1'b0;
    end
    if (wr && a == 4'h2) m_len[7:0]  = d;
    if (wr && a == 4'h3) m_len[15:8] = d;
  endfunction

  task automatic applyStimulus(input logic [3:0] a, input logic wr, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    bus_if.address        = a;
    bus_if.data_write     = wr;
    bus_if.data_in        = d;
    bus_if.crc_byte_ready = rdy;
    #1;
    checkOutput("crc_clear", bus_if.crc_clear, model_valid() ? 1'b0 : (m_ph == 1));
    checkOutput("crc_byte_valid", bus_if.crc_byte_valid, model_valid());
    checkOutput("crc_byte", bus_if.crc_byte, (q.size() != 0) ? q[0] : 8'h00);
    checkOutput("done_irq", bus_if.done_irq, m_done);
    checkOutput($sformatf("data_out[%0h]", a), bus_if.data_out, model_read(a));
    last_read = bus_if.data_out;
    if (bus_if.crc_byte_valid && rdy) sent.push_back(bus_if.crc_byte);
    @(posedge clk);
    model_step(a, wr, d, rdy);
  endtask

  function automatic logic [31:0] packed_sent();
    logic [31:0] acc;
    acc = '0;
    foreach (sent[i]) acc = {acc[23:0], sent[i]};
    return acc;
  endfunction

  initial begin
    int         r;
    logic       rdy;
    rst                   = 1'b1;
    bus_if.address        = 4'h4;
    bus_if.data_write     = 1'b0;
    bus_if.data_in        = 8'h00;
    bus_if.crc_byte_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_status", bus_if.data_out, 8'h01);
    checkOutput("rst_valid", bus_if.crc_byte_valid, 1'b0);
    checkOutput("rst_byte", bus_if.crc_byte, 8'h00);
    checkOutput("rst_clear", bus_if.crc_clear, 1'b0);
    checkOutput("rst_irq", bus_if.done_irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Basic three-byte frame.
    applyStimulus(4'h2, 1'b1, 8'd3, 1'b1);
    applyStimulus(4'h3, 1'b1, 8'd0, 1'b1);
    applyStimulus(4'h1, 1'b1, 8'h31, 1'b1);
    applyStimulus(4'h1, 1'b1, 8'h32, 1'b1);
    applyStimulus(4'h1, 1'b1, 8'h33, 1'b1);
    sent.delete();
    applyStimulus(4'h0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(4'(4 + i % 4), 1'b0, 8'h00, 1'b1);
    checkOutput("frame_bytes", packed_sent(), 32'h00313233);
    applyStimulus(4'h4, 1'b0, 8'h00, 1'b1);
    checkOutput("frame_status", last_read, 8'h09);
    applyStimulus(4'h6, 1'b0, 8'h00, 1'b1);
    checkOutput("frame_remain", last_read, 8'h00);

    // Engine stalls with a byte presented.
    applyStimulus(4'h2, 1'b1, 8'd2, 1'b0);
    applyStimulus(4'h1, 1'b1, 8'hA5, 1'b0);
    applyStimulus(4'h1, 1'b1, 8'h5A, 1'b0);
    sent.delete();
    applyStimulus(4'h0, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(4'h6, 1'b0, 8'h00, 1'b0);
    checkOutput("stall_remain", last_read, 8'h02);
    checkOutput("stall_no_pop", sent.size(), 0);
    for (int i = 0; i < 4; i++) applyStimulus(4'h5, 1'b0, 8'h00, 1'b1);
    checkOutput("stall_bytes", packed_sent(), 32'h0000A55A);

    // Overflow while idle.
    applyStimulus(4'h0, 1'b1, 8'h04, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(4'h1, 1'b1, 8'(8'h41 + i), 1'b0);
    applyStimulus(4'h5, 1'b0, 8'h00, 1'b0);
    checkOutput("ovf_level", last_read, 8'h04);
    applyStimulus(4'h4, 1'b0, 8'h00, 1'b0);
    checkOutput("ovf_status", last_read, 8'h12);
    applyStimulus(4'h2, 1'b1, 8'd4, 1'b1);
    sent.delete();
    applyStimulus(4'h0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(4'h4, 1'b0, 8'h00, 1'b1);
    checkOutput("ovf_bytes", packed_sent(), 32'h41424344);
    applyStimulus(4'h0, 1'b1, 8'h04, 1'b1);

    // Full FIFO during STREAM, push coinciding with a transfer.
    for (int i = 0; i < 4; i++) applyStimulus(4'h1, 1'b1, 8'(8'h51 + i), 1'b0);
    applyStimulus(4'h2, 1'b1, 8'd6, 1'b0);
    applyStimulus(4'h0, 1'b1, 8'h01, 1'b0);
    applyStimulus(4'h4, 1'b0, 8'h00, 1'b0);
    applyStimulus(4'h4, 1'b0, 8'h00, 1'b0);
    applyStimulus(4'h1, 1'b1, 8'h55, 1'b1);
    applyStimulus(4'h5, 1'b0, 8'h00, 1'b0);
    checkOutput("full_xfer_level", last_read, 8'h04);
    applyStimulus(4'h4, 1'b0, 8'h00, 1'b0);
    checkOutput("full_xfer_status", last_read, 8'h06);
    applyStimulus(4'h1, 1'b1, 8'h56, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(4'h7, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h4, 1'b0, 8'h00, 1'b1);
    checkOutput("full_xfer_done", last_read, 8'h09);

    // Abort part-way through a frame.
    applyStimulus(4'h2, 1'b1, 8'd4, 1'b1);
    applyStimulus(4'h1, 1'b1, 8'h61, 1'b1);
    applyStimulus(4'h1, 1'b1, 8'h62, 1'b1);
    applyStimulus(4'h0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'h6, 1'b0, 8'h00, 1'b1);
    checkOutput("abort_pre_remain", last_read, 8'h02);
    applyStimulus(4'h0, 1'b1, 8'h02, 1'b1);
    applyStimulus(4'h4, 1'b0, 8'h00, 1'b1);
    checkOutput("abort_status", last_read, 8'h01);
    applyStimulus(4'h6, 1'b0, 8'h00, 1'b1);
    checkOutput("abort_remain", last_read, 8'h00);

    // Zero-length frame, then ABORT+START together.
    applyStimulus(4'h2, 1'b1, 8'd0, 1'b1);
    applyStimulus(4'h0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'h5, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h4, 1'b0, 8'h00, 1'b1);
    checkOutput("len0_status", last_read, 8'h09);
    applyStimulus(4'h0, 1'b1, 8'h03, 1'b1);
    applyStimulus(4'h4, 1'b0, 8'h00, 1'b1);
    checkOutput("abort_start_status", last_read, 8'h09);

    // Asynchronous reset in the middle of a stream.
    applyStimulus(4'h2, 1'b1, 8'd3, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'h1, 1'b1, 8'(8'h71 + i), 1'b0);
    applyStimulus(4'h0, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'h6, 1'b0, 8'h00, 1'b0);
    #2;
    bus_if.data_write = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    checkOutput("arst_valid", bus_if.crc_byte_valid, 1'b0);
    checkOutput("arst_byte", bus_if.crc_byte, 8'h00);
    checkOutput("arst_irq", bus_if.done_irq, 1'b0);
    checkOutput("arst_remain", bus_if.data_out, 8'h00);
    bus_if.address = 4'h5;
    #1;
    checkOutput("arst_level", bus_if.data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      r   = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 3) != 0);
      if (r < 30)      applyStimulus(4'h1, 1'b1, 8'($urandom), rdy);
      else if (r < 38) applyStimulus(4'h2, 1'b1, 8'($urandom_range(0, 7)), rdy);
      else if (r < 40) applyStimulus(4'h3, 1'b1, 8'h00, rdy);
      else if (r < 50) applyStimulus(4'h0, 1'b1, 8'h01, rdy);
      else if (r < 54) applyStimulus(4'h0, 1'b1, 8'($urandom_range(0, 7)), rdy);
      else if (r < 57) applyStimulus(4'($urandom_range(4, 15)), 1'b1, 8'($urandom), rdy);
      else             applyStimulus(4'($urandom_range(0, 15)), 1'b0, 8'h00, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
